// File: rtl/pipe_mux_reg.sv
// N-to-1 operand mux with a one-cycle output register, stall hold and flush.
// Define PIPE_MUX_SEL_CHECK_EN to add the sticky sel_err out-of-range flag.
module pipe_mux_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
`ifdef PIPE_MUX_SEL_CHECK_EN
  output logic [CNT_W-1:0]        stall_cnt,
  output logic                    sel_err
`else
  output logic [CNT_W-1:0]        stall_cnt
`endif
);

  logic [WIDTH-1:0] selWord;
  logic             selInRange;
  logic [WIDTH-1:0] loadWord;
  logic             loadValid;

  // Out-of-range selects fall through to the last input.
  always_comb begin
    selWord = in_bus[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int i = 0; i < NUM_IN - 1; i++) begin
      if (sel == SEL_W'(i))
        selWord = in_bus[i*WIDTH +: WIDTH];
    end
  end

  assign selInRange = (int'(sel) < NUM_IN);

`ifdef PIPE_MUX_SEL_CHECK_EN
  assign loadWord  = selInRange ? selWord : '0;
  assign loadValid = selInRange & in_valid;
`else
  assign loadWord  = selWord;
  assign loadValid = in_valid;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      stall_cnt <= '0;
    end else if (stall) begin
      if (stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      out       <= loadWord;
      out_valid <= loadValid;
      out_sel   <= sel;
      stall_cnt <= '0;
    end
  end

`ifdef PIPE_MUX_SEL_CHECK_EN
  // Sticky: only a load cycle evaluates sel; only Reset clears.
  always_ff @(posedge Clk) begin
    if (Reset)
      sel_err <= 1'b0;
    else if (!flush && !stall && !selInRange)
      sel_err <= 1'b1;
  end
`endif

endmodule
